// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/LSU request and memory port bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int BITSIZE = 32
);
    logic               if_read_i;
    logic [BITSIZE-1:0] if_addr_i;
    logic [31:0]        if_data_o;
    logic               if_valid_o;
    logic               flush_i;

    logic               lsu_read_i;
    logic               lsu_write_i;
    logic [BITSIZE-1:0] lsu_addr_i;
    logic [31:0]        lsu_wdata_i;
    logic [3:0]         lsu_be_i;
    logic [31:0]        lsu_data_o;
    logic               lsu_valid_o;

    logic [BITSIZE-1:0] mem_addr_o;
    logic [31:0]        mem_wdata_o;
    logic [3:0]         mem_be_o;
    logic               mem_read_o;
    logic               mem_write_o;
    logic [31:0]        mem_data_i;
    logic               mem_valid_i;

    // Arbiter side: serves the pipeline requesters and drives the memory port.
    modport slave (
        input  if_read_i, if_addr_i, flush_i,
        input  lsu_read_i, lsu_write_i, lsu_addr_i, lsu_wdata_i, lsu_be_i,
        input  mem_data_i, mem_valid_i,
        output if_data_o, if_valid_o, lsu_data_o, lsu_valid_o,
        output mem_addr_o, mem_wdata_o, mem_be_o, mem_read_o, mem_write_o
    );

    // Environment side: pipeline requesters plus the memory/cache model.
    modport master (
        output if_read_i, if_addr_i, flush_i,
        output lsu_read_i, lsu_write_i, lsu_addr_i, lsu_wdata_i, lsu_be_i,
        output mem_data_i, mem_valid_i,
        input  if_data_o, if_valid_o, lsu_data_o, lsu_valid_o,
        input  mem_addr_o, mem_wdata_o, mem_be_o, mem_read_o, mem_write_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and the LSU
module mem_port_arbiter #(
    parameter int BITSIZE      = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset_i,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, IF_ACC, LSU_ACC, IF_FLUSH} state_t;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   starve_cnt;
    logic [BITSIZE-1:0] mem_addr_q;
    logic               lsu_req;
    logic               force_if;
    logic               grant_lsu;
    logic               grant_if;
    logic               done;

    // LSU wins unless IF has waited through STARVE_LIMIT back-to-back LSU grants.
    assign lsu_req   = bus.lsu_read_i | bus.lsu_write_i;
    assign force_if  = bus.if_read_i & ~bus.flush_i & (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign grant_lsu = (state == IDLE) & lsu_req & ~force_if;
    assign grant_if  = (state == IDLE) & ~grant_lsu & bus.if_read_i & ~bus.flush_i;
    assign done      = (state != IDLE) & bus.mem_valid_i;

    assign bus.mem_addr_o = mem_addr_q;

    // State register.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state: a memory request can never be cancelled, so a flushed fetch waits it out.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_lsu)     state_next = LSU_ACC;
                else if (grant_if) state_next = IF_ACC;
            end
            LSU_ACC: begin
                if (bus.mem_valid_i) state_next = IDLE;
            end
            IF_ACC: begin
                if (bus.mem_valid_i)  state_next = IDLE;
                else if (bus.flush_i) state_next = IF_FLUSH;
            end
            IF_FLUSH: begin
                if (bus.mem_valid_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Starvation counter: counts LSU grants that bypassed a waiting fetch.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            starve_cnt <= '0;
        end else if (grant_lsu) begin
            if (!bus.if_read_i)
                starve_cnt <= '0;
            else if (starve_cnt != CNT_W'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + CNT_W'(1);
        end else if (grant_if) begin
            starve_cnt <= '0;
        end
    end

    // Memory request registers and response capture; valid pulses last one cycle.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            mem_addr_q      <= '0;
            bus.mem_wdata_o <= '0;
            bus.mem_be_o    <= '0;
            bus.mem_read_o  <= 1'b0;
            bus.mem_write_o <= 1'b0;
            bus.if_data_o   <= '0;
            bus.if_valid_o  <= 1'b0;
            bus.lsu_data_o  <= '0;
            bus.lsu_valid_o <= 1'b0;
        end else begin
            bus.if_valid_o  <= 1'b0;
            bus.lsu_valid_o <= 1'b0;
            if (grant_lsu) begin
                // A simultaneous read+write request is issued as the write only.
                mem_addr_q      <= bus.lsu_addr_i;
                bus.mem_wdata_o <= bus.lsu_wdata_i;
                bus.mem_be_o    <= bus.lsu_write_i ? bus.lsu_be_i : 4'hF;
                bus.mem_write_o <= bus.lsu_write_i;
                bus.mem_read_o  <= ~bus.lsu_write_i;
            end else if (grant_if) begin
                mem_addr_q      <= bus.if_addr_i;
                bus.mem_wdata_o <= '0;
                bus.mem_be_o    <= 4'hF;
                bus.mem_write_o <= 1'b0;
                bus.mem_read_o  <= 1'b1;
            end else if (done) begin
                mem_addr_q      <= '0;
                bus.mem_wdata_o <= '0;
                bus.mem_be_o    <= '0;
                bus.mem_write_o <= 1'b0;
                bus.mem_read_o  <= 1'b0;
                if (state == LSU_ACC) begin
                    bus.lsu_valid_o <= 1'b1;
                    if (!bus.mem_write_o) bus.lsu_data_o <= bus.mem_data_i;
                end
                if (state == IF_ACC && !bus.flush_i) begin
                    bus.if_valid_o <= 1'b1;
                    bus.if_data_o  <= bus.mem_data_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset_i;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.BITSIZE(32)) ifc ();

    mem_port_arbiter #(.BITSIZE(32), .STARVE_LIMIT(4)) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (ifc)
    );

    typedef struct packed {
        logic        is_lsu;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(logic is_lsu, logic [31:0] data);
        exp_t e;
        e.is_lsu = is_lsu;
        e.data   = data;
        sb.push_back(e);
    endtask

    task automatic check_pulse(string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_lsu_valid"}, 32'(ifc.lsu_valid_o), 32'(e.is_lsu));
        check({tag, "_if_valid"}, 32'(ifc.if_valid_o), 32'(!e.is_lsu));
        if (e.is_lsu) check({tag, "_lsu_data"}, ifc.lsu_data_o, e.data);
        else          check({tag, "_if_data"}, ifc.if_data_o, e.data);
    endtask

    task automatic check_idle_outputs(string tag);
        check({tag, "_mem_read"},  32'(ifc.mem_read_o), 32'd0);
        check({tag, "_mem_write"}, 32'(ifc.mem_write_o), 32'd0);
        check({tag, "_mem_addr"},  ifc.mem_addr_o, 32'd0);
        check({tag, "_mem_be"},    32'(ifc.mem_be_o), 32'd0);
        check({tag, "_mem_wdata"}, ifc.mem_wdata_o, 32'd0);
        check({tag, "_if_valid"},  32'(ifc.if_valid_o), 32'd0);
        check({tag, "_lsu_valid"}, 32'(ifc.lsu_valid_o), 32'd0);
        check({tag, "_if_data"},   ifc.if_data_o, 32'd0);
        check({tag, "_lsu_data"},  ifc.lsu_data_o, 32'd0);
    endtask

    // Waits (bounded) for a memory request, checks its address, answers with single-cycle
    // latency and checks the resulting valid pulse one cycle later.
    task automatic do_txn(string tag, logic is_lsu, logic [31:0] exp_addr, logic [31:0] rdata);
        int n;
        n = 0;
        while (!(ifc.mem_read_o || ifc.mem_write_o) && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 32'(ifc.mem_read_o | ifc.mem_write_o), 32'd1);
        check({tag, "_addr"}, ifc.mem_addr_o, exp_addr);
        ifc.mem_valid_i = 1'b1;
        ifc.mem_data_i  = rdata;
        push_exp(is_lsu, rdata);
        tick();
        ifc.mem_valid_i = 1'b0;
        check_pulse(tag);
    endtask

    initial begin
        logic [31:0] last_if;
        reset_i         = 1'b1;
        ifc.if_read_i   = 1'b0;
        ifc.if_addr_i   = '0;
        ifc.flush_i     = 1'b0;
        ifc.lsu_read_i  = 1'b0;
        ifc.lsu_write_i = 1'b0;
        ifc.lsu_addr_i  = '0;
        ifc.lsu_wdata_i = '0;
        ifc.lsu_be_i    = '0;
        ifc.mem_data_i  = '0;
        ifc.mem_valid_i = 1'b0;

        // T1: reset state, then reset in the middle of an LSU access
        tick();
        tick();
        check_idle_outputs("t1_por");
        reset_i = 1'b0;
        tick();
        ifc.lsu_read_i = 1'b1;
        ifc.lsu_addr_i = 32'h80;
        tick();
        check("t1_lsu_req", 32'(ifc.mem_read_o), 32'd1);
        check("t1_lsu_addr", ifc.mem_addr_o, 32'h80);
        #2;
        reset_i = 1'b1;
        #1;
        check_idle_outputs("t1_async");
        ifc.lsu_read_i = 1'b0;
        tick();
        reset_i = 1'b0;
        tick();
        ifc.mem_valid_i = 1'b1;
        ifc.mem_data_i  = 32'hA5A5A5A5;
        tick();
        ifc.mem_valid_i = 1'b0;
        check_idle_outputs("t1_late_valid");
        tick();
        check("t1_late_valid2", 32'(ifc.lsu_valid_o), 32'd0);

        // T2: simultaneous requests, LSU first, then IF
        ifc.if_read_i  = 1'b1;
        ifc.if_addr_i  = 32'h100;
        ifc.lsu_read_i = 1'b1;
        ifc.lsu_addr_i = 32'h200;
        tick();
        check("t2_c1_read", 32'(ifc.mem_read_o), 32'd1);
        check("t2_c1_write", 32'(ifc.mem_write_o), 32'd0);
        check("t2_c1_addr", ifc.mem_addr_o, 32'h200);
        check("t2_c1_be", 32'(ifc.mem_be_o), 32'hF);
        tick();
        check("t2_c2_hold", ifc.mem_addr_o, 32'h200);
        tick();
        ifc.mem_valid_i = 1'b1;
        ifc.mem_data_i  = 32'hDEADBEEF;
        push_exp(1'b1, 32'hDEADBEEF);
        tick();
        ifc.mem_valid_i = 1'b0;
        check_pulse("t2_c4");
        check("t2_c4_read_drop", 32'(ifc.mem_read_o), 32'd0);
        ifc.lsu_read_i = 1'b0;
        tick();
        check("t2_c5_if_read", 32'(ifc.mem_read_o), 32'd1);
        check("t2_c5_if_addr", ifc.mem_addr_o, 32'h100);
        ifc.mem_valid_i = 1'b1;
        ifc.mem_data_i  = 32'h11111111;
        push_exp(1'b0, 32'h11111111);
        tick();
        ifc.mem_valid_i = 1'b0;
        check_pulse("t2_c6");
        ifc.if_read_i = 1'b0;
        tick();

        // T3: both requesters hold continuously -> L,L,L,L,I,L,L,L,L,I
        ifc.if_read_i  = 1'b1;
        ifc.if_addr_i  = 32'h300;
        ifc.lsu_read_i = 1'b1;
        ifc.lsu_addr_i = 32'h400;
        for (int i = 0; i < 10; i++) begin
            logic is_l;
            is_l = ((i % 5) != 4);
            do_txn($sformatf("t3_g%0d", i), is_l, is_l ? 32'h400 : 32'h300, 32'h30000000 + 32'(i));
        end
        last_if = 32'h30000009;
        ifc.if_read_i  = 1'b0;
        ifc.lsu_read_i = 1'b0;
        tick();

        // T4: fetch flushed while outstanding; request held, no pulse, then a fresh fetch
        ifc.if_read_i = 1'b1;
        ifc.if_addr_i = 32'h100;
        tick();
        check("t4_req", 32'(ifc.mem_read_o), 32'd1);
        check("t4_addr", ifc.mem_addr_o, 32'h100);
        ifc.flush_i = 1'b1;
        tick();
        ifc.flush_i   = 1'b0;
        ifc.if_read_i = 1'b0;
        check("t4_held1", 32'(ifc.mem_read_o), 32'd1);
        check("t4_held1_addr", ifc.mem_addr_o, 32'h100);
        tick();
        check("t4_held2", 32'(ifc.mem_read_o), 32'd1);
        ifc.mem_valid_i = 1'b1;
        ifc.mem_data_i  = 32'hBADBAD00;
        tick();
        ifc.mem_valid_i = 1'b0;
        check("t4_no_pulse", 32'(ifc.if_valid_o), 32'd0);
        check("t4_drop", 32'(ifc.mem_read_o), 32'd0);
        check("t4_if_data_hold", ifc.if_data_o, last_if);
        ifc.if_read_i = 1'b1;
        ifc.if_addr_i = 32'h200;
        do_txn("t4_refetch", 1'b0, 32'h200, 32'hCAFE0001);
        ifc.if_read_i = 1'b0;
        tick();

        // T5: flush and completion in the same IF_ACC cycle
        ifc.if_read_i = 1'b1;
        ifc.if_addr_i = 32'h500;
        tick();
        check("t5_addr", ifc.mem_addr_o, 32'h500);
        ifc.flush_i     = 1'b1;
        ifc.mem_valid_i = 1'b1;
        ifc.mem_data_i  = 32'h55555555;
        ifc.if_read_i   = 1'b0;
        tick();
        ifc.flush_i     = 1'b0;
        ifc.mem_valid_i = 1'b0;
        check("t5_no_pulse", 32'(ifc.if_valid_o), 32'd0);
        check("t5_if_data_hold", ifc.if_data_o, 32'hCAFE0001);
        check("t5_drop", 32'(ifc.mem_read_o), 32'd0);
        ifc.lsu_read_i = 1'b1;
        ifc.lsu_addr_i = 32'h600;
        tick();
        check("t5_idle_grant", 32'(ifc.mem_read_o), 32'd1);
        do_txn("t5_load", 1'b1, 32'h600, 32'h66666666);
        ifc.lsu_read_i = 1'b0;
        tick();

        // T6: store (read also raised: write must win), load data left untouched
        ifc.lsu_write_i = 1'b1;
        ifc.lsu_read_i  = 1'b1;
        ifc.lsu_addr_i  = 32'h40;
        ifc.lsu_wdata_i = 32'h12345678;
        ifc.lsu_be_i    = 4'b0011;
        tick();
        check("t6_write", 32'(ifc.mem_write_o), 32'd1);
        check("t6_read", 32'(ifc.mem_read_o), 32'd0);
        check("t6_addr", ifc.mem_addr_o, 32'h40);
        check("t6_wdata", ifc.mem_wdata_o, 32'h12345678);
        check("t6_be", 32'(ifc.mem_be_o), 32'h3);
        tick();
        check("t6_hold_wdata", ifc.mem_wdata_o, 32'h12345678);
        ifc.mem_valid_i = 1'b1;
        ifc.mem_data_i  = 32'hFFFFFFFF;
        push_exp(1'b1, 32'h66666666);
        tick();
        ifc.mem_valid_i = 1'b0;
        check_pulse("t6_done");
        check("t6_write_drop", 32'(ifc.mem_write_o), 32'd0);
        ifc.lsu_write_i = 1'b0;
        ifc.lsu_read_i  = 1'b0;
        tick();
        check("t6_pulse_one_cycle", 32'(ifc.lsu_valid_o), 32'd0);
        check("t6_sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
